pipe_flow_ctrl: RTL and testbench

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

---
 rtl/pipe_flow_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_flow_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline stall/flush controller with exception masking and stall watchdog
module pipe_flow_ctrl #(
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned MASK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_for_id,
  input  logic        stallreq_for_ex,
  input  logic        stallreq_for_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_MASK  = 2'd3
  } state_t;

  localparam logic [3:0]  MASK_LOAD = 4'(MASK_CYCLES);
  localparam logic [16:0] LIMIT     = 17'(STALL_LIMIT);

  state_t      state;
  state_t      state_next;
  logic [3:0]  mask_cnt;
  logic [3:0]  mask_cnt_next;
  logic [31:0] cap_pc;
  logic [15:0] consec_cnt;
  logic        any_req;
  logic        stall_active;

  assign any_req      = stallreq_for_id | stallreq_for_ex | stallreq_for_mem;
  assign stall_active = |stall;
  assign ctrl_state   = rst ? ST_RUN : state;

  // Per-stage hold mask: deepest requesting stage wins; a flush cycle never holds.
  always_comb begin
    stall = 6'b000000;
    if (!rst && state != ST_FLUSH) begin
      if (stallreq_for_mem)     stall = 6'b011111;
      else if (stallreq_for_ex) stall = 6'b001111;
      else if (stallreq_for_id) stall = 6'b000111;
    end
  end

  // Next-state, mask countdown and flush/redirect outputs.
  always_comb begin
    state_next    = state;
    mask_cnt_next = mask_cnt;
    flush         = 1'b0;
    new_pc        = 32'h0;
    case (state)
      ST_RUN, ST_STALL: begin
        if (excp_valid)   state_next = ST_FLUSH;
        else if (any_req) state_next = ST_STALL;
        else              state_next = ST_RUN;
      end
      ST_FLUSH: begin
        state_next    = ST_MASK;
        mask_cnt_next = MASK_LOAD;
        flush         = !rst;
        new_pc        = rst ? 32'h0 : cap_pc;
      end
      ST_MASK: begin
        // Exceptions are deliberately ignored here, including on the final cycle.
        if (mask_cnt <= 4'd1) begin
          state_next    = any_req ? ST_STALL : ST_RUN;
          mask_cnt_next = 4'd0;
        end else begin
          mask_cnt_next = mask_cnt - 4'd1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // State register, mask counter and redirect target capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      mask_cnt <= 4'd0;
      cap_pc   <= 32'h0;
    end else begin
      state    <= state_next;
      mask_cnt <= mask_cnt_next;
      if ((state == ST_RUN || state == ST_STALL) && state_next == ST_FLUSH)
        cap_pc <= excp_pc;
    end
  end

  // Stall statistics: saturating total count, consecutive run and sticky watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= 32'h0;
      consec_cnt    <= 16'h0;
      stall_timeout <= 1'b0;
    end else if (stall_active) begin
      if (stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (consec_cnt != 16'hFFFF)        consec_cnt   <= consec_cnt + 16'd1;
      if (({1'b0, consec_cnt} + 17'd1) >= LIMIT) stall_timeout <= 1'b1;
    end else begin
      consec_cnt <= 16'h0;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - directed and randomized checks of pipe_flow_ctrl against a behavioural model
module tb_pipe_flow_ctrl;

  localparam int LIMIT = 4;
  localparam int MASKC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_id, req_ex, req_mem, excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Behavioural model: pending flush, remaining masked cycles, stalled flag.
  bit          m_known;
  bit          m_flushing;
  int          m_mask_left;
  bit          m_in_stall;
  logic [31:0] m_pc;
  longint      m_cycles;
  int          m_run;
  bit          m_to;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.STALL_LIMIT(LIMIT), .MASK_CYCLES(MASKC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_for_id(req_id), .stallreq_for_ex(req_ex), .stallreq_for_mem(req_mem),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] want_stall();
    if (rst || m_flushing) return 6'b000000;
    if (req_mem) return 6'b011111;
    if (req_ex)  return 6'b001111;
    if (req_id)  return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [1:0] want_state();
    if (rst)             return 2'd0;
    if (m_flushing)      return 2'd2;
    if (m_mask_left > 0) return 2'd3;
    return m_in_stall ? 2'd1 : 2'd0;
  endfunction

  task automatic model_check();
    chk("model.stall", 32'(stall), 32'(want_stall()));
    chk("model.flush", 32'(flush), 32'(!rst && m_flushing));
    chk("model.new_pc", new_pc, (!rst && m_flushing) ? m_pc : 32'h0);
    chk("model.ctrl_state", 32'(ctrl_state), 32'(want_state()));
    if (m_known) begin
      chk("model.stall_cycles", stall_cycles, 32'(m_cycles));
      chk("model.stall_timeout", 32'(stall_timeout), 32'(m_to));
    end
  endtask

  task automatic model_update();
    bit s, anyr;
    s    = (want_stall() != 6'b0);
    anyr = req_id | req_ex | req_mem;
    if (rst) begin
      m_known = 1; m_flushing = 0; m_mask_left = 0; m_in_stall = 0;
      m_pc = 32'h0; m_cycles = 0; m_run = 0; m_to = 0;
      return;
    end
    if (s) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (m_run < 65535) m_run++;
      if (m_run >= LIMIT) m_to = 1;
    end else begin
      m_run = 0;
    end
    if (m_flushing) begin
      m_flushing  = 0;
      m_mask_left = MASKC;
    end else if (m_mask_left > 0) begin
      m_mask_left--;
      if (m_mask_left == 0) m_in_stall = anyr;
    end else if (excp_valid) begin
      m_flushing = 1; m_pc = excp_pc; m_in_stall = 0;
    end else begin
      m_in_stall = anyr;
    end
  endtask

  task automatic tick();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit i, input bit e, input bit m, input bit x,
                       input logic [31:0] pc, input bit r);
    req_id = i; req_ex = e; req_mem = m; excp_valid = x; excp_pc = pc; rst = r;
    #1;
  endtask

  initial begin
    m_known = 0; m_flushing = 0; m_mask_left = 0; m_in_stall = 0;
    m_pc = 0; m_cycles = 0; m_run = 0; m_to = 0;

    // Reset with noisy inputs: outputs forced idle.
    drive(1, 1, 1, 1, 32'hDEAD_BEEF, 1);
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 1);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("rst.stall_cycles", stall_cycles, 32'h0);
    chk("rst.timeout", 32'(stall_timeout), 32'h0);
    chk("rst.state", 32'(ctrl_state), 32'h0);
    tick();

    // id + mem together for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 32'h0, 0);
      chk("idmem.stall", 32'(stall), 32'h1F);
      tick();
      chk("idmem.state", 32'(ctrl_state), 32'd1);
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("idmem.cycles", stall_cycles, 32'd3);
    tick();
    chk("idmem.back_run", 32'(ctrl_state), 32'd0);

    // Single exception pulse in RUN.
    drive(0, 0, 0, 1, 32'hBFC0_0380, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("excp.flush", 32'(flush), 32'h1);
    chk("excp.new_pc", new_pc, 32'hBFC0_0380);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("excp.mask_state", 32'(ctrl_state), 32'd3);
      chk("excp.mask_flush", 32'(flush), 32'h0);
      tick();
    end
    chk("excp.run", 32'(ctrl_state), 32'd0);
    tick();

    // ex stall and exception together, then exceptions held through FLUSH and MASK.
    drive(0, 1, 0, 1, 32'h8000_0100, 0);
    chk("exexc.stall", 32'(stall), 32'h0F);
    tick();
    drive(0, 1, 0, 1, 32'h1234_5678, 0);
    chk("exexc.flush_stall", 32'(stall), 32'h0);
    chk("exexc.flush", 32'(flush), 32'h1);
    chk("exexc.new_pc", new_pc, 32'h8000_0100);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("mask.no_flush", 32'(flush), 32'h0);
      chk("mask.new_pc", new_pc, 32'h0);
      chk("mask.stall", 32'(stall), 32'h0F);
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("mask.exit_stall", 32'(ctrl_state), 32'd1);
    chk("mask.exit_flush", 32'(flush), 32'h0);
    tick();

    // Watchdog: burst of 3, gap, burst of 4.
    for (int k = 0; k < 3; k++) begin drive(1, 0, 0, 0, 32'h0, 0); tick(); end
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("wd.after_burst1", 32'(stall_timeout), 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 32'h0, 0);
      chk("wd.during_burst2", 32'(stall_timeout), 32'h0);
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("wd.set", 32'(stall_timeout), 32'h1);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("wd.sticky", 32'(stall_timeout), 32'h1);
    tick();

    // Reset on the FLUSH cycle.
    drive(0, 0, 0, 1, 32'hCAFE_0000, 0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("rstflush.flush_forced", 32'(flush), 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("rstflush.state", 32'(ctrl_state), 32'd0);
    chk("rstflush.flush", 32'(flush), 32'h0);
    chk("rstflush.new_pc", new_pc, 32'h0);
    chk("rstflush.cycles", stall_cycles, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 63) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
